round_sequencer: RTL and testbench
==================================

Name: round_sequencer

Overview:
- Multi-round sequencer for the encoder datapath.
- On a single start it loads the input word into the state register, then runs ROUNDS rounds.
- Each round fires the five step units in fixed order (parity, rotate, permute, revaluate, round-constant), with a start/ready handshake per unit, and writes the round result back.
- Supplies the round index to the RC unit; pulses ready when the whole operation completes.

Parameters:
- ROUNDS, 24, number of rounds per operation (legal range 1..2^RIDX_W).
- RIDX_W, 5, width of round_idx.
- WDOG_CYCLES, 255, watchdog limit in cycles per step wait (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  operation request; sampled only in IDLE.
- abort  input  1  synchronous abort; returns to IDLE next cycle from any state.
- ready_par, ready_rot, ready_per, ready_rev, ready_RC  input  1 each  step-unit completion.
- start_par, start_rot, start_per, start_rev, start_RC  output  1 each  one-cycle step-unit start pulse.
- ld_fr  output  1  one-cycle load of input into state register.
- ld_fw  output  1  one-cycle write-back of round result into state register.
- round_idx  output  RIDX_W  current round, 0..ROUNDS-1.
- busy  output  1  high in every state except IDLE.
- ready  output  1  one-cycle done pulse.
- err  output  1  watchdog error flag (tied 0 when feature is off).

Behaviour:
- Reset (asynchronous, any state): state=IDLE, round_idx=0, all outputs 0.
- All outputs are Moore, decoded from registered state.
- States: IDLE, LOAD, then an issue/wait pair for each step (PAR_I/PAR_W, ROT_I/ROT_W, PER_I/PER_W, REV_I/REV_W, RC_I/RC_W), then WB, DONE.
- IDLE: start=1 -> LOAD; otherwise stay. round_idx=0.
- LOAD: ld_fr=1 for one cycle -> PAR_I.
- X_I: start_X=1 for exactly one cycle -> X_W. Ready from the unit is ignored during the issue cycle.
- X_W: stay while ready_X=0; ready_X=1 -> next step's issue state.
  - Step order: PAR -> ROT -> PER -> REV -> RC.
  - RC_W with ready_RC=1 -> WB.
  - Ready inputs of units not currently awaited are ignored.
- WB: ld_fw=1 for one cycle.
  - If round_idx==ROUNDS-1 -> DONE.
  - Otherwise round_idx increments and the state goes to PAR_I.
- DONE: ready=1 for one cycle -> IDLE; round_idx clears to 0 on entering IDLE.
- round_idx is stable for the whole round, from PAR_I through WB.
- Minimum latency (every ready arrives in the cycle after its start): LOAD 1 + ROUNDS*11 + DONE 1.
  - With start sampled in cycle 0, ready is high in cycle 2+11*ROUNDS (266 for ROUNDS=24).
- start while busy: ignored, no queuing. start held high through DONE starts a new operation from IDLE on the following cycle.
- abort: highest priority after rst; any state -> IDLE next cycle.
  - No ready pulse; round_idx=0.
  - Any start_X in that cycle still completes its single pulse.
- Simultaneous start and abort in IDLE: abort wins, stay IDLE.

Optional Feature:
- Macro ROUND_SEQ_WDOG_EN.
- Defined:
  - An 8-bit (clog2(WDOG_CYCLES+1)) counter clears on every X_I and counts each cycle in X_W.
  - Reaching WDOG_CYCLES without ready_X -> IDLE and err=1.
  - err stays set until the next accepted start or rst; no ready pulse is issued.
- Undefined: no counter logic; err tied 0; X_W waits indefinitely.

Test Plan:
- ROUNDS=2, zero-wait units (ready one cycle after start), start pulsed in cycle 0 -> ld_fr in cycle 1; start_par in cycles 2 and 13; ld_fw in cycles 12 and 23; ready in cycle 24 only; round_idx 0 then 1; busy cycles 1..24.
- ROUNDS=2, ready_per delayed 5 cycles in round 0 -> ready moves from cycle 24 to cycle 29; start_rev fires one cycle after ready_per; no duplicate start pulses.
- Stray ready_rot=1 asserted during PAR_W and during PAR_I -> no state advance; start_rot only after ready_par.
- abort asserted in cycle 15 of a ROUNDS=2 run -> IDLE in cycle 16; busy=0; round_idx=0; no ready; new start in cycle 20 gives ready in cycle 44.
- rst pulsed mid-ROT_W -> all outputs 0 immediately (asynchronous, before next edge); start after release gives normal 24-cycle run.
- With ROUND_SEQ_WDOG_EN, WDOG_CYCLES=10, ready_RC never asserted -> err=1 and IDLE after 10 cycles in RC_W; next start clears err; a run with all readies gives err=0.

Source files
------------

// File: rtl/round_sequencer.sv
// Multi-round sequencer: loads the state word, then runs ROUNDS rounds of five step units.
// The optional per-step watchdog is enabled by defining ROUND_SEQ_WDOG_EN.
module round_sequencer #(
    parameter int ROUNDS      = 24,
    parameter int RIDX_W      = 5,
    parameter int WDOG_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              ready_par,
    input  logic              ready_rot,
    input  logic              ready_per,
    input  logic              ready_rev,
    input  logic              ready_RC,
    output logic              start_par,
    output logic              start_rot,
    output logic              start_per,
    output logic              start_rev,
    output logic              start_RC,
    output logic              ld_fr,
    output logic              ld_fw,
    output logic [RIDX_W-1:0] round_idx,
    output logic              busy,
    output logic              ready,
    output logic              err
);

    // Handshake: each X_I state pulses start_X for one cycle; X_W then waits for
    // ready_X high on a rising edge. Readies are only looked at in their own X_W.
    typedef enum logic [3:0] {
        S_IDLE, S_LOAD,
        S_PAR_I, S_PAR_W, S_ROT_I, S_ROT_W, S_PER_I, S_PER_W,
        S_REV_I, S_REV_W, S_RC_I, S_RC_W,
        S_WB, S_DONE
    } state_t;

    localparam logic [RIDX_W-1:0] LAST_IDX = RIDX_W'(ROUNDS - 1);

    state_t            state_q, state_d;
    logic [RIDX_W-1:0] idx_q, idx_d;
    logic              timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD:  state_d = S_PAR_I;
            S_PAR_I: state_d = S_PAR_W;
            S_PAR_W: if (ready_par) state_d = S_ROT_I;
            S_ROT_I: state_d = S_ROT_W;
            S_ROT_W: if (ready_rot) state_d = S_PER_I;
            S_PER_I: state_d = S_PER_W;
            S_PER_W: if (ready_per) state_d = S_REV_I;
            S_REV_I: state_d = S_REV_W;
            S_REV_W: if (ready_rev) state_d = S_RC_I;
            S_RC_I:  state_d = S_RC_W;
            S_RC_W:  if (ready_RC) state_d = S_WB;
            S_WB: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_PAR_I;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (timeout) state_d = S_IDLE;
        if (abort)   state_d = S_IDLE;
        // round_idx is zero whenever the sequencer sits in IDLE
        if (state_d == S_IDLE) idx_d = '0;
    end

`ifdef ROUND_SEQ_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);

    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            err_q, err_d;
    logic            in_wait, in_issue, wait_rdy;

    always_comb begin
        in_wait  = 1'b0;
        wait_rdy = 1'b0;
        case (state_q)
            S_PAR_W: begin in_wait = 1'b1; wait_rdy = ready_par; end
            S_ROT_W: begin in_wait = 1'b1; wait_rdy = ready_rot; end
            S_PER_W: begin in_wait = 1'b1; wait_rdy = ready_per; end
            S_REV_W: begin in_wait = 1'b1; wait_rdy = ready_rev; end
            S_RC_W:  begin in_wait = 1'b1; wait_rdy = ready_RC;  end
            default: ;
        endcase
        in_issue = (state_q == S_PAR_I) || (state_q == S_ROT_I) || (state_q == S_PER_I) ||
                   (state_q == S_REV_I) || (state_q == S_RC_I);
        wdog_d = wdog_q;
        if (in_issue)     wdog_d = '0;
        else if (in_wait) wdog_d = wdog_q + 1'b1;
        timeout = in_wait && !wait_rdy && (wdog_q == WD_W'(WDOG_CYCLES - 1));
        err_d = err_q;
        if ((state_q == S_IDLE) && start && !abort) err_d = 1'b0;
        else if (timeout && !abort)                 err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    assign ld_fr     = (state_q == S_LOAD);
    assign start_par = (state_q == S_PAR_I);
    assign start_rot = (state_q == S_ROT_I);
    assign start_per = (state_q == S_PER_I);
    assign start_rev = (state_q == S_REV_I);
    assign start_RC  = (state_q == S_RC_I);
    assign ld_fw     = (state_q == S_WB);
    assign ready     = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign round_idx = idx_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer (ROUNDS=2): unit responders, event scoreboard, per-cycle busy/idx/err model.
module tb_round_sequencer;
  localparam int ROUNDS = 2;
  localparam int RIDX_W = 5;
  localparam int WDOG   = 10;
  localparam int NC     = 128;

  logic clk = 1'b0;
  logic rst, start, abort;
  logic [4:0] rdy;
  logic start_par, start_rot, start_per, start_rev, start_RC;
  logic ld_fr, ld_fw, busy, ready, err;
  logic [RIDX_W-1:0] round_idx;
  logic [4:0] st;

  round_sequencer #(.ROUNDS(ROUNDS), .RIDX_W(RIDX_W), .WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .ready_par(rdy[0]), .ready_rot(rdy[1]), .ready_per(rdy[2]), .ready_rev(rdy[3]), .ready_RC(rdy[4]),
    .start_par(start_par), .start_rot(start_rot), .start_per(start_per), .start_rev(start_rev),
    .start_RC(start_RC), .ld_fr(ld_fr), .ld_fw(ld_fw), .round_idx(round_idx),
    .busy(busy), .ready(ready), .err(err)
  );

  assign st = {start_RC, start_rev, start_per, start_rot, start_par};

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = -1;
  bit mon_en = 1'b0;
  logic [31:0] exp_q[$];
  logic exp_busy[NC];
  logic exp_err[NC];
  logic [RIDX_W-1:0] exp_idx[NC];
  int dly[5][ROUNDS];
  int st_cyc[5];
  int st_dly[5];
  int rd_cyc[5];
  int stray_lo, stray_hi;

  // Scoreboard: events are coded as type*100000 + cycle (1 ld_fr, 2 start_par, 3 ld_fw, 4 ready)
  always @(negedge clk) begin
    logic [3:0] ev;
    logic [31:0] code, e;
    int ri;
    if (mon_en && cyc >= 0 && cyc < NC) begin
      n_cmp++;
      if (busy !== exp_busy[cyc]) begin
        n_err++; $display("FAIL busy c%0d: got %b want %b", cyc, busy, exp_busy[cyc]);
      end
      n_cmp++;
      if (round_idx !== exp_idx[cyc]) begin
        n_err++; $display("FAIL round_idx c%0d: got %0d want %0d", cyc, round_idx, exp_idx[cyc]);
      end
      n_cmp++;
      if (err !== exp_err[cyc]) begin
        n_err++; $display("FAIL err c%0d: got %b want %b", cyc, err, exp_err[cyc]);
      end
      ev = {ready, ld_fw, start_par, ld_fr};
      for (int k = 0; k < 4; k++) begin
        if (ev[k]) begin
          code = 32'((k + 1) * 100000 + cyc);
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++; $display("FAIL event c%0d: got code %0d want none", cyc, code);
          end else begin
            e = exp_q.pop_front();
            if (e !== code) begin
              n_err++; $display("FAIL event c%0d: got code %0d want %0d", cyc, code, e);
            end
          end
        end
      end
      for (int u = 1; u < 5; u++) begin
        if (st[u]) begin
          n_cmp++;
          if (rd_cyc[u-1] != cyc - 1) begin
            n_err++; $display("FAIL step_order c%0d: start unit %0d, prev ready at %0d want %0d",
                              cyc, u, rd_cyc[u-1], cyc - 1);
          end
        end
      end
      for (int u = 0; u < 5; u++) begin
        if (st[u]) begin
          ri = int'(round_idx);
          st_cyc[u] = cyc;
          st_dly[u] = (ri < ROUNDS) ? dly[u][ri] : 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    rdy = '0;
    for (int u = 0; u < 5; u++) begin
      if (cyc == st_cyc[u] + 1 + st_dly[u]) begin
        rdy[u] = 1'b1;
        rd_cyc[u] = cyc;
      end
    end
    if (cyc >= stray_lo && cyc <= stray_hi) rdy[1] = 1'b1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic init_test();
    exp_q.delete();
    for (int c = 0; c < NC; c++) begin
      exp_busy[c] = 1'b0; exp_err[c] = 1'b0; exp_idx[c] = '0;
    end
    for (int u = 0; u < 5; u++) begin
      for (int r = 0; r < ROUNDS; r++) dly[u][r] = 0;
      st_cyc[u] = -1000; st_dly[u] = 0; rd_cyc[u] = -1000;
    end
    stray_lo = -1; stray_hi = -2;
    cyc = -1;
    mon_en = 1'b1;
  endtask

  // Expected trace of one operation accepted in cycle s; abort_c >= 0 truncates it there.
  task automatic push_op(input int s, input int abort_c);
    int dcum, endc, rdyc, n;
    int fw[ROUNDS];
    dcum = 0;
    if (abort_c < 0 || s + 1 <= abort_c) exp_q.push_back(32'(100000 + s + 1));
    for (int r = 0; r < ROUNDS; r++) begin
      if (abort_c < 0 || s + 2 + 11 * r + dcum <= abort_c)
        exp_q.push_back(32'(200000 + s + 2 + 11 * r + dcum));
      for (int u = 0; u < 5; u++) dcum += dly[u][r];
      fw[r] = s + 12 + 11 * r + dcum;
      if (abort_c < 0 || fw[r] <= abort_c) exp_q.push_back(32'(300000 + fw[r]));
    end
    rdyc = fw[ROUNDS-1] + 1;
    if (abort_c < 0) exp_q.push_back(32'(400000 + rdyc));
    endc = (abort_c >= 0) ? abort_c : rdyc;
    for (int c = s + 1; c <= endc && c < NC; c++) begin
      exp_busy[c] = 1'b1;
      n = 0;
      for (int r = 0; r < ROUNDS; r++) if (fw[r] < c) n++;
      if (n > ROUNDS - 1) n = ROUNDS - 1;
      exp_idx[c] = RIDX_W'(n);
    end
  endtask

  task automatic check_drained(input string name);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL %s drained: got %0d pending want 0, next %0d", name, exp_q.size(), exp_q[0]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; rdy = '0;
    #12;
    n_cmp++;
    if ({st, ld_fr, ld_fw, busy, ready, err, round_idx} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got %b want 0", {st, ld_fr, ld_fw, busy, ready, err, round_idx});
    end
    @(posedge clk); #1; rst = 1'b0;
    init_test();
    for (int c = 0; c <= 3; c++) step();
    mon_en = 1'b0;
  endtask

  task automatic test_zero_wait();
    init_test();
    for (int c = 0; c <= 30; c++) begin
      step();
      if (c == 0) begin start = 1'b1; push_op(0, -1); end
      if (c == 24) begin
        #5;
        n_cmp++;
        if (ready !== 1'b1) begin
          n_err++; $display("FAIL zero_wait ready@24: got %b want 1", ready);
        end
      end
    end
    check_drained("zero_wait");
    mon_en = 1'b0;
  endtask

  task automatic test_stall();
    init_test();
    dly[2][0] = 5;
    for (int c = 0; c <= 34; c++) begin
      step();
      if (c == 0) begin start = 1'b1; push_op(0, -1); end
    end
    check_drained("stall");
    mon_en = 1'b0;
  endtask

  task automatic test_stray();
    init_test();
    dly[0][0] = 3;
    stray_lo = 2; stray_hi = 5;
    for (int c = 0; c <= 32; c++) begin
      step();
      if (c == 0) begin start = 1'b1; push_op(0, -1); end
    end
    check_drained("stray");
    mon_en = 1'b0;
  endtask

  task automatic test_abort();
    init_test();
    push_op(0, 15);
    push_op(20, -1);
    for (int c = 0; c <= 50; c++) begin
      step();
      if (c == 0 || c == 20) start = 1'b1;
      if (c == 15) abort = 1'b1;
      if (c == 17) begin start = 1'b1; abort = 1'b1; end
    end
    check_drained("abort");
    mon_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    init_test();
    push_op(0, -1);
    push_op(25, -1);
    for (int c = 0; c <= 55; c++) begin
      step();
      if (c <= 25) start = 1'b1;
    end
    check_drained("back_to_back");
    mon_en = 1'b0;
  endtask

  task automatic test_async_reset();
    init_test();
    dly[1][0] = 4;
    push_op(0, 5);
    for (int c = 0; c <= 6; c++) begin
      step();
      if (c == 0) start = 1'b1;
    end
    mon_en = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({st, ld_fr, ld_fw, busy, ready, err, round_idx} !== '0) begin
      n_err++; $display("FAIL async_reset: got %b want 0", {st, ld_fr, ld_fw, busy, ready, err, round_idx});
    end
    check_drained("async_reset_pre");
    rst = 1'b0;
    init_test();
    for (int c = 0; c <= 30; c++) begin
      step();
      if (c == 0) begin start = 1'b1; push_op(0, -1); end
    end
    check_drained("async_reset_run");
    mon_en = 1'b0;
  endtask

`ifdef ROUND_SEQ_WDOG_EN
  task automatic test_wdog();
    init_test();
    dly[4][0] = 1000;
    push_op(0, 20);
    for (int c = 21; c <= 25; c++) exp_err[c] = 1'b1;
    for (int c = 0; c <= 55; c++) begin
      step();
      if (c == 0 || c == 25) start = 1'b1;
      if (c == 11) begin dly[4][0] = 0; push_op(25, -1); end
      if (c == 21) begin
        #5;
        n_cmp++;
        if (err !== 1'b1 || busy !== 1'b0) begin
          n_err++; $display("FAIL wdog_timeout: got err=%b busy=%b want err=1 busy=0", err, busy);
        end
      end
    end
    check_drained("wdog");
    mon_en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_stray();
    test_abort();
    test_back_to_back();
    test_async_reset();
`ifdef ROUND_SEQ_WDOG_EN
    test_wdog();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
